// File: rtl/riscv_lsu.sv
// Load/store unit between the RV32I execute stage and a single-port RAM with 1-cycle read latency.
// Handles byte/half/word accesses, sub-word read-modify-write, load extension, misalignment and an LED register.
`timescale 1ns/1ps
module riscv_lsu #(
  parameter logic [31:0] LED_ADDR = 32'h000000A0,
  parameter int          LED_W    = 4,
  parameter int          RAM_AW   = 30
) (
  input  logic              clk,
  input  logic              reset,
  // valid/ready: a request transfers on a rising edge where req_valid and req_ready are both 1;
  // the requester holds req_* stable until then. resp_valid is a one-cycle pulse with no backpressure.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  output logic [LED_W-1:0]  leds,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW     = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t             state_q;
  logic [31:0]        addr_q;
  logic [1:0]         size_q;
  logic               unsigned_q;
  logic [15:0]        wdata_q;
  logic [LED_W-1:0]   leds_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               accept;
  logic               misaligned;
  logic               led_hit;
  logic               word_store;
  logic [31:0]        merged;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept     = req_valid && (state_q == IDLE);
  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign led_hit    = (req_addr[31:2] == LED_ADDR[31:2]);
  assign word_store = accept && !misaligned && !led_hit && req_we && (req_size == 2'd2);

  always_comb begin
    merged = ram_q;
    if (size_q == 2'd0) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // The RAM address follows the live request while idle so reads start at the accept edge.
  always_comb begin
    ram_addr  = (state_q == IDLE) ? req_addr[RAM_AW+1:2] : addr_q[RAM_AW+1:2];
    ram_wren  = 1'b0;
    ram_wdata = 32'b0;
    if (word_store) begin
      ram_wren  = 1'b1;
      ram_wdata = req_wdata;
    end else if (state_q == RMW) begin
      ram_wren  = 1'b1;
      ram_wdata = merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'b0;
      size_q     <= 2'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 16'b0;
      leds_q     <= '0;
      rdata_q    <= 32'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            rdata_q    <= 32'b0;
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else if (led_hit) begin
              if (req_we && (req_addr[1:0] == 2'b00)) leds_q <= req_wdata[LED_W-1:0];
              if (!req_we)
                rdata_q <= load_ext({{(32-LED_W){1'b0}}, leds_q}, req_size,
                                    req_addr[1:0], req_unsigned);
              state_q <= RESP;
            end else if (req_we) begin
              state_q <= (req_size == 2'd2) ? RESP : RMW;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          rdata_q <= load_ext(ram_q, size_q, addr_q[1:0], unsigned_q);
          state_q <= RESP;
        end
        RMW: state_q <= RESP;
        RESP: begin
          rdata_q <= 32'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign leds       = leds_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between the RV32I execute stage and the single-port on-chip RAM, which has a synchronous read with 1-cycle latency.
- Handles the following on a valid/ready request interface:
  - byte, half and word accesses;
  - read-modify-write for sub-word stores;
  - sign or zero extension on loads;
  - misalignment detection;
  - a memory-mapped LED register.
- Replaces the core's direct RAM/LED coupling, so the core only sees a request/response handshake.

Parameters:
- LED_ADDR, 32'h000000A0, byte address of the LED register (RAM word 40); matched on bits [31:2].
- LED_W, 4, width of the LED output register.
- RAM_AW, 30, width of the RAM word address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: zero-extend (LBU/LHU) instead of sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word value is taken from the low bits.
- resp_valid  output  1  single-cycle pulse marking request completion.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size request; qualified by resp_valid.
- ram_addr  output  RAM_AW  RAM word address.
- ram_wdata  output  32  RAM write data.
- ram_wren  output  1  RAM write enable.
- ram_q  input  32  RAM read data, valid the cycle after the address is sampled.
- leds  output  LED_W  LED register.

Behaviour:

Reset (reset = 0, asynchronous):
- state = IDLE.
- leds = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, ram_wren = 0.
- Any held address and data registers are cleared.
- A reset during RD_WAIT or RMW aborts the operation: no RAM write occurs and no response is produced.

FSM states:
- IDLE: req_ready = 1. Accept = req_valid & req_ready.
- In IDLE, ram_addr = req_addr[31:2] (combinational). In all other states ram_addr = the held address.
- Misalignment: error if req_size = 3, or (size = 1 and addr[0] = 1), or (size = 2 and addr[1:0] != 0).
  - On accept, go to RESP with resp_err = 1 and no RAM or LED access.
- LED hit (addr[31:2] = LED_ADDR[31:2], aligned):
  - Store: leds <= req_wdata[LED_W-1:0] only when addr[1:0] = 0 (byte lane 0 written); otherwise leds are unchanged.
  - Load: data = {0, leds}, then extended per size/unsigned.
  - Next state RESP, latency 1.
- RAM aligned word store: ram_wren = 1 and ram_wdata = req_wdata combinationally in the accept cycle, so the write lands at the accept edge. Next state RESP.
- RAM load: the RAM samples the address at the accept edge. Next state RD_WAIT.
  - RD_WAIT: select the lane from ram_q using offset addr[1:0] (byte: ram_q[8*off +: 8]; half: ram_q[16*off[1] +: 16]).
  - Extend: sign-extend, or zero-extend if req_unsigned.
  - Register into resp_rdata and go to RESP.
- RAM sub-word store: the accept edge reads the word. Next state RMW.
  - RMW: merged word = ram_q with the addressed lane(s) replaced by req_wdata low bits.
  - ram_wren = 1 and ram_wdata = merged for exactly this cycle.
  - Next state RESP.
- RESP: resp_valid = 1 for one cycle, req_ready = 0, then return to IDLE.

Latency and handshake:
- Latency from the accept edge to the resp_valid cycle is 1 (error, LED, word store) or 2 (load, sub-word store).
- req_ready = 0 in every state except IDLE. A request presented while busy is not accepted; the requester holds it until accepted.
- resp_valid has no backpressure.
- Request fields are latched at accept, so changes to req_* after accept have no effect.
- The unit never issues ram_wren outside the accept cycle of a word store or the RMW cycle.
- Back-to-back requests: the earliest next accept is the cycle after RESP.

Test Plan:
1. Word store 0xDEADBEEF to addr 0x10, then LW 0x10 → RAM word 4 = 0xDEADBEEF; load response 2 cycles after accept, resp_rdata = 0xDEADBEEF, resp_err = 0.
2. With word 4 = 0xDEADBEEF:
   - LB 0x13 → 0xFFFFFFDE.
   - LBU 0x13 → 0x000000DE.
   - LH 0x10 → 0xFFFFBEEF.
   - LHU 0x12 → 0x0000DEAD.
3. SB 0x55 to addr 0x11 on word 0xDEADBEEF → exactly one ram_wren pulse, in the RMW cycle, with ram_wdata = 0xDEAD55EF; subsequent LW reads 0xDEAD55EF.
4. SW 0x0000000B to 0xA0 → leds = 4'hB, no ram_wren. LW 0xA0 → resp_rdata = 0x0000000B.
5. LW 0x12, SH 0x11, and req_size = 3 → each gives resp_err = 1 and resp_rdata = 0 after 1 cycle, with no RAM or LED change.
6. Reset (reset = 0) asserted during RMW of SB to 0x20 → no ram_wren, no resp_valid, leds = 0, req_ready = 1 after release; RAM word 8 is unchanged.
